pbs_ctrl: RTL

Battle control unit for the turn-based battle system. It sequences each turn: player attack half-turn, then AI attack half-turn. It drives the select and strobe lines of the battle datapath (target, p_move, actr, calc_dmg, app_dmg) and reads back p_hp/AI_hp to detect knockout. It also exposes a move handshake to the input front end and game status to the display.

---
 rtl/pbs_pkg.sv | 30 +++
 rtl/pbs_phase_timer.sv | 38 +++
 rtl/pbs_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pbs_pkg.sv
// Shared types and encodings for the battle controller: FSM states,
// winner codes and the target/attacker select polarities.
package pbs_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_P,
        P_CALC,
        P_APPLY,
        P_CHECK,
        AI_CALC,
        AI_APPLY,
        AI_CHECK,
        DONE
    } state_e;

    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_PLAYER = 2'b01;
    localparam logic [1:0] WIN_AI     = 2'b10;
    localparam logic [1:0] WIN_DRAW   = 2'b11;

    localparam logic TGT_PLAYER  = 1'b0;
    localparam logic TGT_AI      = 1'b1;
    localparam logic ACTR_PLAYER = 1'b0;
    localparam logic ACTR_AI     = 1'b1;

    // Wide enough for the largest damage-calculation hold (15 cycles).
    localparam int TIMER_W = 4;

endpackage

// File: rtl/pbs_phase_timer.sv
// Loadable down-counter: load with N-1 and done_o rises on the N-th cycle
// after the load, then the timer goes idle until the next load.
module pbs_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q;

    assign done_o = active_q && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (active_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
        if (rst) begin
            active_q <= 1'b0;
        end else if (load_i) begin
            active_q <= 1'b1;
        end else if (done_o) begin
            active_q <= 1'b0;
        end
    end

endmodule

// File: rtl/pbs_ctrl.sv
// Turn sequencer for the battle datapath: player half-turn, then AI half-turn,
// with knockout/draw detection. Every output comes straight from a register.
module pbs_ctrl
    import pbs_pkg::*;
#(
    parameter int CALC_CYCLES = 2,
    parameter int MAX_TURNS   = 15,
    parameter int TURN_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              move_valid,
    input  logic [1:0]        move_sel,
    input  logic [3:0]        p_hp,
    input  logic [3:0]        AI_hp,
    output logic              target,
    output logic [1:0]        p_move,
    output logic              actr,
    output logic              calc_dmg,
    output logic              app_dmg,
    output logic              move_ready,
    output logic              busy,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic [TURN_W-1:0] turn_count
);

    state_e            state_q;
    logic              target_q, actr_q, calc_q, app_q, ready_q, busy_q, over_q;
    logic [1:0]        p_move_q, winner_q;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic              timer_load, timer_done;

    assign turn_d = turn_q + TURN_W'(1);

    // The timer is armed on the same edge that enters either CALC state.
    assign timer_load = (state_q == WAIT_P && move_valid && ready_q) ||
                        (state_q == P_CHECK && AI_hp != '0);

    pbs_phase_timer #(.CNT_W(TIMER_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (timer_load),
        .val_i  (TIMER_W'(CALC_CYCLES - 1)),
        .done_o (timer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= 1'b0;
            actr_q   <= 1'b0;
            calc_q   <= 1'b0;
            app_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            over_q   <= 1'b0;
            p_move_q <= 2'b00;
            winner_q <= WIN_NONE;
            turn_q   <= '0;
        end else begin
            calc_q  <= 1'b0;
            app_q   <= 1'b0;
            ready_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        turn_q <= '0;
                        if (AI_hp == '0 || p_hp == '0) begin
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            over_q   <= 1'b1;
                            winner_q <= (AI_hp == '0 && p_hp == '0) ? WIN_DRAW :
                                        (AI_hp == '0) ? WIN_PLAYER : WIN_AI;
                        end else begin
                            state_q  <= WAIT_P;
                            busy_q   <= 1'b1;
                            over_q   <= 1'b0;
                            winner_q <= WIN_NONE;
                            ready_q  <= 1'b1;
                            target_q <= TGT_AI;
                            actr_q   <= ACTR_PLAYER;
                        end
                    end
                end
                WAIT_P: begin
                    if (move_valid) begin
                        p_move_q <= move_sel;
                        state_q  <= P_CALC;
                        calc_q   <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                P_CALC: begin
                    if (timer_done) begin
                        state_q <= P_APPLY;
                        app_q   <= 1'b1;
                    end else begin
                        calc_q <= 1'b1;
                    end
                end
                P_APPLY: state_q <= P_CHECK;
                P_CHECK: begin
                    if (AI_hp == '0) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        over_q   <= 1'b1;
                        winner_q <= WIN_PLAYER;
                    end else begin
                        state_q  <= AI_CALC;
                        calc_q   <= 1'b1;
                        target_q <= TGT_PLAYER;
                        actr_q   <= ACTR_AI;
                    end
                end
                AI_CALC: begin
                    if (timer_done) begin
                        state_q <= AI_APPLY;
                        app_q   <= 1'b1;
                    end else begin
                        calc_q <= 1'b1;
                    end
                end
                AI_APPLY: state_q <= AI_CHECK;
                AI_CHECK: begin
                    if (p_hp == '0) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        over_q   <= 1'b1;
                        winner_q <= WIN_AI;
                    end else begin
                        turn_q <= turn_d;
                        if (turn_d == TURN_W'(MAX_TURNS)) begin
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            over_q   <= 1'b1;
                            winner_q <= WIN_DRAW;
                        end else begin
                            state_q  <= WAIT_P;
                            ready_q  <= 1'b1;
                            target_q <= TGT_AI;
                            actr_q   <= ACTR_PLAYER;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    over_q  <= 1'b0;
                end
            endcase
        end
    end

    assign target     = target_q;
    assign p_move     = p_move_q;
    assign actr       = actr_q;
    assign calc_dmg   = calc_q;
    assign app_dmg    = app_q;
    assign move_ready = ready_q;
    assign busy       = busy_q;
    assign game_over  = over_q;
    assign winner     = winner_q;
    assign turn_count = turn_q;

endmodule
